sram_rw_ctrl: RTL and testbench

SRAM_RW_CTRL -- requirements
Module: sram_rw_ctrl

---
 rtl/sram_rw_pkg.sv | 14 +
 rtl/sram_resp_fifo.sv | 48 ++++
 rtl/sram_rw_ctrl.sv | 124 ++++++++++++
 tb/tb_sram_rw_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_rw_pkg.sv
// rtl/sram_rw_pkg.sv - shared sizes and FSM state type for the SRAM read/write controller
package sram_rw_pkg;

  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 64;
  localparam int DEPTH      = 16384;
  localparam int RESP_DEPTH = 2;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sram_resp_fifo.sv
// rtl/sram_resp_fifo.sv - small circular buffer holding read responses in issue order
module sram_resp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  assign pop_data = mem[rd_ptr];

  // Entry storage; contents are only meaningful while counted, so no reset is needed.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping with wrap at DEPTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/sram_rw_ctrl.sv
// rtl/sram_rw_ctrl.sv - zeroes the SRAM after reset, then arbitrates write/read requests onto one port
module sram_rw_ctrl #(
  parameter int ADDR_W     = sram_rw_pkg::ADDR_W,
  parameter int DATA_W     = sram_rw_pkg::DATA_W,
  parameter int DEPTH      = sram_rw_pkg::DEPTH,
  parameter int RESP_DEPTH = sram_rw_pkg::RESP_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  output logic              init_done,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  import sram_rw_pkg::*;

  localparam int CW = $clog2(RESP_DEPTH + 1);

  state_t            state;
  logic [ADDR_W-1:0] init_cnt;
  logic              last_was_write;
  logic              rd_pending;
  logic [CW-1:0]     fifo_count;
  logic              fifo_pop;
  logic [CW:0]       occupancy;
  logic              running;
  logic              read_elig;
  logic              wr_fire;
  logic              rd_fire;

  // Reset is folded in combinationally so every handshake/enable is low while it is held.
  assign running    = !reset && (state == RUN);
  assign init_done  = running;
  assign resp_valid = !reset && (fifo_count != '0);
  assign fifo_pop   = resp_valid && resp_ready;

  // Responses already owed (buffered plus the one in flight) minus the one leaving this cycle.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, rd_pending} - {{CW{1'b0}}, fifo_pop};
  assign read_elig = running && (occupancy < (CW + 1)'(RESP_DEPTH));

  // Round-robin: on contention the type not granted last wins.
  assign r_ready = read_elig && (!w_valid || last_was_write);
  assign w_ready = running && (!(r_valid && read_elig) || !last_was_write);
  assign wr_fire = w_valid && w_ready;
  assign rd_fire = r_valid && r_ready;

  // SRAM port: zero-fill during INIT, otherwise the granted access, otherwise idle zeroes.
  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (!reset) begin
      if (state == INIT) begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_addr  = init_cnt;
      end else if (wr_fire) begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_addr  = w_addr;
        sram_wdata = w_data;
      end else if (rd_fire) begin
        sram_en    = 1'b1;
        sram_addr  = r_addr;
      end
    end
  end

  // Controller FSM: init sweep, grant history and the in-flight read marker.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= INIT;
      init_cnt       <= '0;
      last_was_write <= 1'b1;
      rd_pending     <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == ADDR_W'(DEPTH - 1)) begin
            state <= RUN;
          end
        end
        RUN: begin
          rd_pending <= rd_fire;
          if (wr_fire) begin
            last_was_write <= 1'b1;
          end else if (rd_fire) begin
            last_was_write <= 1'b0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  sram_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (DATA_W)
  ) u_resp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rd_pending),
    .push_data (sram_rdata),
    .pop       (fifo_pop),
    .pop_data  (resp_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_sram_rw_ctrl.sv
// tb/tb_sram_rw_ctrl.sv - randomized bench for sram_rw_ctrl against a queue-based reference model
module tb_sram_rw_ctrl;

  localparam int AW = 14;
  localparam int DW = 64;
  localparam int DEPTH = 16384;
  localparam int RESP_DEPTH = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          init_done;
  logic          w_valid = 1'b0;
  logic          w_ready;
  logic [AW-1:0] w_addr = '0;
  logic [DW-1:0] w_data = '0;
  logic          r_valid = 1'b0;
  logic          r_ready;
  logic [AW-1:0] r_addr = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_data;
  logic          sram_en;
  logic          sram_wmode;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata = '0;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  sram_rw_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .init_done  (init_done),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .r_addr     (r_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .sram_en    (sram_en),
    .sram_wmode (sram_wmode),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // Behavioural single-port SRAM, pre-filled with garbage so the zero sweep matters.
  logic [DW-1:0] sram_mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) sram_mem[i] = {$urandom, $urandom};
  end
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) sram_mem[sram_addr] <= sram_wdata;
      else            sram_rdata <= sram_mem[sram_addr];
    end
  end

  // Reference model: contents, owed responses with the cycle each becomes visible, grant history.
  typedef struct {
    logic [DW-1:0] d;
    int            rdy;
  } ent_t;
  ent_t          q[$];
  logic [DW-1:0] mem_m [DEPTH];
  int            since_rst = 0;
  int            cyc = 0;
  bit            m_last_w = 1'b1;

  bit            e_rf, e_wf, e_rvalid;
  bit            o_rf, o_wf, o_rvalid, o_rready, o_init_done;
  logic [DW-1:0] o_rdata;
  logic [AW-1:0] o_addr;

  task automatic cycle(input logic rst, input logic wv, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic rv, input logic [AW-1:0] ra,
                       input logic rr);
    bit run, init, pop, elig;
    logic [AW-1:0] x_addr;
    @(negedge clock);
    reset = rst; w_valid = wv; w_addr = wa; w_data = wd;
    r_valid = rv; r_addr = ra; resp_ready = rr;
    #1;
    run  = !rst && (since_rst >= DEPTH);
    init = !rst && !run;
    e_rvalid = !rst && (q.size() > 0) && (q[0].rdy <= cyc);
    pop  = e_rvalid && rr;
    elig = run && ((q.size() - int'(pop)) < RESP_DEPTH);
    e_rf = rv && elig && (!wv || m_last_w);
    e_wf = run && wv && !e_rf;
    x_addr = init ? AW'(since_rst) : e_wf ? wa : e_rf ? ra : '0;
    o_rf = r_valid && r_ready; o_wf = w_valid && w_ready;
    o_rvalid = resp_valid; o_rready = r_ready; o_init_done = init_done;
    o_rdata = resp_data; o_addr = sram_addr;
    total += 7;
    if (o_wf !== e_wf) begin bad++; $display("FAIL wgrant cyc=%0d: got %b want %b", cyc, o_wf, e_wf); end
    if (o_rf !== e_rf) begin bad++; $display("FAIL rgrant cyc=%0d: got %b want %b", cyc, o_rf, e_rf); end
    if (resp_valid !== e_rvalid) begin bad++; $display("FAIL resp_valid cyc=%0d: got %b want %b", cyc, resp_valid, e_rvalid); end
    if (init_done !== run) begin bad++; $display("FAIL init_done cyc=%0d: got %b want %b", cyc, init_done, run); end
    if (sram_en !== (init || e_wf || e_rf)) begin bad++; $display("FAIL sram_en cyc=%0d: got %b want %b", cyc, sram_en, init || e_wf || e_rf); end
    if (sram_addr !== x_addr || sram_wmode !== (init || e_wf)) begin
      bad++; $display("FAIL sram_addr/wmode cyc=%0d: got %h/%b want %h/%b", cyc, sram_addr, sram_wmode, x_addr, init || e_wf);
    end
    if (sram_wdata !== (e_wf ? wd : '0)) begin bad++; $display("FAIL sram_wdata cyc=%0d: got %h want %h", cyc, sram_wdata, e_wf ? wd : '0); end
    if (e_rvalid) begin
      total++;
      if (resp_data !== q[0].d) begin bad++; $display("FAIL resp_data cyc=%0d: got %h want %h", cyc, resp_data, q[0].d); end
    end
    if (rst) begin
      since_rst = 0; q.delete(); m_last_w = 1'b1;
      foreach (mem_m[i]) mem_m[i] = '0;
    end else begin
      if (init) since_rst++;
      if (pop) void'(q.pop_front());
      if (e_rf) q.push_back('{mem_m[ra], cyc + 2});
      if (e_wf) mem_m[wa] = wd;
      if (e_rf) m_last_w = 1'b0;
      else if (e_wf) m_last_w = 1'b1;
    end
    cyc++;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      cycle(1, 1, 14'h5, 64'h1, 1, 14'h6, 1);
      total++;
      if ({sram_en, w_ready, r_ready, resp_valid, init_done} !== 5'b0) begin
        bad++; $display("FAIL reset_outputs: got %b want 00000", {sram_en, w_ready, r_ready, resp_valid, init_done});
      end
    end
  endtask

  task automatic test_init_and_rr();
    int zero_cycles = 0;
    int hs = 0;
    string order = "";
    for (int k = 0; k < DEPTH + 4; k++) begin
      cycle(0, 1, AW'(14'h100 + $urandom_range(0, 255)), {$urandom, $urandom}, 1, AW'($urandom_range(0, 255)), 1);
      if (k < DEPTH) begin
        if (!o_init_done) zero_cycles++;
        if (o_rf || o_wf) hs++;
      end else begin
        order = {order, o_rf ? "R" : (o_wf ? "W" : "-")};
      end
    end
    total += 3;
    if (zero_cycles != DEPTH) begin bad++; $display("FAIL init_length: got %0d want %0d", zero_cycles, DEPTH); end
    if (hs != 0) begin bad++; $display("FAIL init_handshakes: got %0d want 0", hs); end
    if (order != "RWRW") begin bad++; $display("FAIL rr_order: got %s want RWRW", order); end
    for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_raw();
    int t_hs = -1;
    int t_val = -1;
    cycle(0, 0, 0, 0, 1, 14'h1234, 1);
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 0, 0, 0, 0, 1);
      if (o_rvalid) begin
        total++;
        if (o_rdata !== 64'h0) begin bad++; $display("FAIL read_1234: got %h want 0", o_rdata); end
      end
    end
    cycle(0, 1, 14'h5, 64'hDEADBEEF_CAFEF00D, 0, 0, 1);
    cycle(0, 0, 0, 0, 1, 14'h5, 1);
    if (o_rf) t_hs = cyc - 1;
    for (int k = 0; k < 6; k++) begin
      cycle(0, 0, 0, 0, 0, 0, 1);
      if (o_rvalid && t_val < 0) begin
        t_val = cyc - 1;
        total++;
        if (o_rdata !== 64'hDEADBEEF_CAFEF00D) begin bad++; $display("FAIL raw_data: got %h want deadbeefcafef00d", o_rdata); end
      end
    end
    total++;
    if (t_hs < 0 || t_val - t_hs != 2) begin bad++; $display("FAIL raw_latency: got %0d want 2", t_val - t_hs); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [8];
    int idx = 0, nresp = 0, first = -1, last = -1, hs = 0;
    for (int i = 0; i < 8; i++) addrs[i] = AW'($urandom);
    for (int k = 0; k < 30; k++) begin
      cycle(0, 0, 0, 0, idx < 8, (idx < 8) ? addrs[idx] : '0, 1);
      if (e_rf) idx++;
      if (o_rvalid) begin nresp++; if (first < 0) first = k; last = k; end
    end
    total += 2;
    if (nresp != 8) begin bad++; $display("FAIL b2b_count: got %0d want 8", nresp); end
    if (last - first != 7) begin bad++; $display("FAIL b2b_span: got %0d want 7", last - first); end
    idx = 0; nresp = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(0, 0, 0, 0, idx < 8, (idx < 8) ? addrs[idx] : '0, 0);
      if (e_rf) idx++;
      if (o_rf) hs++;
    end
    total += 2;
    if (hs != 2) begin bad++; $display("FAIL stall_issued: got %0d want 2", hs); end
    if (o_rready !== 1'b0) begin bad++; $display("FAIL stall_r_ready: got %b want 0", o_rready); end
    for (int k = 0; k < 40; k++) begin
      cycle(0, 0, 0, 0, idx < 8, (idx < 8) ? addrs[idx] : '0, 1);
      if (e_rf) idx++;
      if (o_rvalid) nresp++;
    end
    total++;
    if (nresp != 8) begin bad++; $display("FAIL stall_returned: got %0d want 8", nresp); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      cycle(0, ($urandom_range(0, 1) == 1), AW'($urandom_range(0, 15)), {$urandom, $urandom},
            ($urandom_range(0, 2) != 0), AW'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7));
    end
    for (int k = 0; k < 6; k++) cycle(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_mid_reset();
    int issued = 0, nresp = 0;
    cycle(0, 0, 0, 0, 1, 14'h10, 0);
    cycle(0, 0, 0, 0, 1, 14'h11, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    total++;
    if (o_rvalid !== 1'b1) begin bad++; $display("FAIL pre_reset_buffered: got %b want 1", o_rvalid); end
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 14'h7, 64'h77, 1, 14'h8, 1);
    total += 2;
    if (o_rvalid !== 1'b0) begin bad++; $display("FAIL post_reset_valid: got %b want 0", o_rvalid); end
    if (o_addr !== '0) begin bad++; $display("FAIL post_reset_addr: got %h want 0", o_addr); end
    for (int k = 1; k < DEPTH; k++) cycle(0, 1, 14'h7, 64'h77, 1, 14'h8, 1);
    for (int k = 0; k < 20; k++) begin
      cycle(0, 0, 0, 0, k < 10, AW'($urandom_range(0, 15)), 1);
      if (e_rf) issued++;
      if (o_rvalid) nresp++;
    end
    total++;
    if (nresp != issued) begin bad++; $display("FAIL stale_count: got %0d want %0d", nresp, issued); end
  endtask

  initial begin
    test_reset();
    test_init_and_rr();
    test_raw();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
